excp_commit_ctrl: RTL and testbench

- Commit-side exception/ERTN sequencer after the MEM/WB boundary.
- Takes the committing instruction's exception vector, picks the highest-priority cause and issues one registered CSR update (ESTAT/ERA/BADV/TLBEHI fields).
- Flushes every pipeline register for a fixed number of cycles, then hands the new fetch PC to the frontend with a valid/ready handshake.
- Busy while sequencing; commit inputs are ignored until back in IDLE.

---
 rtl/excp_commit_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_excp_commit_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/excp_commit_ctrl.sv
// Commit-side exception/ERTN sequencer: picks the winning cause, issues one CSR
// update strobe, flushes the pipeline for FLUSH_CYCLES cycles, then redirects fetch.
module excp_commit_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [15:0] commit_excp_num,
    input  logic [31:0] commit_vaddr,
    input  logic        commit_is_ertn,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era_i,
    input  logic        redirect_ready,
    output logic        busy,
    output logic        flush_o,
    output logic        csr_excp_we,
    output logic        csr_ertn_we,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_era_o,
    output logic        va_error,
    output logic [31:0] bad_va,
    output logic        excp_tlb,
    output logic        excp_tlbrefill,
    output logic [18:0] excp_tlb_vppn,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CSR,
        S_FLUSH,
        S_REDIRECT
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] target_q;

    logic        busy_q, flush_q, excp_we_q, ertn_we_q;
    logic [5:0]  ecode_q;
    logic [8:0]  esub_q;
    logic [31:0] era_q, bad_va_q, rpc_q;
    logic        va_err_q, tlb_q, refill_q, rv_q;

    logic [3:0]  cause_idx;
    logic [5:0]  dec_ecode;
    logic [8:0]  dec_esub;
    logic        dec_va_err, dec_tlb, dec_refill;
    logic [31:0] dec_bad_va;
    logic        is_excp, trigger;

    assign is_excp = |commit_excp_num;
    assign trigger = (state_q == S_IDLE) && commit_valid && (is_excp || commit_is_ertn);

    // Lowest set bit wins.
    always_comb begin
        cause_idx = '0;
        casez (commit_excp_num)
            16'b???????????????1: cause_idx = 4'd0;
            16'b??????????????10: cause_idx = 4'd1;
            16'b?????????????100: cause_idx = 4'd2;
            16'b????????????1000: cause_idx = 4'd3;
            16'b???????????10000: cause_idx = 4'd4;
            16'b??????????100000: cause_idx = 4'd5;
            16'b?????????1000000: cause_idx = 4'd6;
            16'b????????10000000: cause_idx = 4'd7;
            16'b???????100000000: cause_idx = 4'd8;
            16'b??????1000000000: cause_idx = 4'd9;
            16'b?????10000000000: cause_idx = 4'd10;
            16'b????100000000000: cause_idx = 4'd11;
            16'b???1000000000000: cause_idx = 4'd12;
            16'b??10000000000000: cause_idx = 4'd13;
            16'b?100000000000000: cause_idx = 4'd14;
            16'b1000000000000000: cause_idx = 4'd15;
            default:              cause_idx = 4'd0;
        endcase
    end

    always_comb begin
        dec_ecode  = '0;
        dec_esub   = '0;
        dec_va_err = 1'b0;
        dec_bad_va = '0;
        case (cause_idx)
            4'd0:    dec_ecode = 6'h00;
            4'd1:    dec_ecode = 6'h08;
            4'd2:    dec_ecode = 6'h3F;
            4'd3:    dec_ecode = 6'h03;
            4'd4:    dec_ecode = 6'h07;
            4'd5:    dec_ecode = 6'h0B;
            4'd6:    dec_ecode = 6'h0C;
            4'd7:    dec_ecode = 6'h0D;
            4'd8:    dec_ecode = 6'h0E;
            4'd9:    dec_ecode = 6'h09;
            4'd10: begin
                dec_ecode = 6'h08;
                dec_esub  = 9'd1;
            end
            4'd11:   dec_ecode = 6'h3F;
            4'd12:   dec_ecode = 6'h04;
            4'd13:   dec_ecode = 6'h07;
            4'd14:   dec_ecode = 6'h02;
            default: dec_ecode = 6'h01;
        endcase
        // Fetch-side causes report the PC, data-side causes the access address.
        if (cause_idx >= 4'd1 && cause_idx <= 4'd4) begin
            dec_va_err = 1'b1;
            dec_bad_va = commit_pc;
        end else if (cause_idx >= 4'd9) begin
            dec_va_err = 1'b1;
            dec_bad_va = commit_vaddr;
        end
    end

    assign dec_tlb    = (cause_idx >= 4'd2 && cause_idx <= 4'd4) || (cause_idx >= 4'd11);
    assign dec_refill = (cause_idx == 4'd2) || (cause_idx == 4'd11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            target_q  <= '0;
            busy_q    <= 1'b0;
            flush_q   <= 1'b0;
            excp_we_q <= 1'b0;
            ertn_we_q <= 1'b0;
            ecode_q   <= '0;
            esub_q    <= '0;
            era_q     <= '0;
            va_err_q  <= 1'b0;
            bad_va_q  <= '0;
            tlb_q     <= 1'b0;
            refill_q  <= 1'b0;
            rv_q      <= 1'b0;
            rpc_q     <= RESET_PC;
        end else begin
            // Strobe and cause fields live for the single CSR cycle only.
            excp_we_q <= 1'b0;
            ertn_we_q <= 1'b0;
            ecode_q   <= '0;
            esub_q    <= '0;
            era_q     <= '0;
            va_err_q  <= 1'b0;
            bad_va_q  <= '0;
            tlb_q     <= 1'b0;
            refill_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q <= S_CSR;
                        busy_q  <= 1'b1;
                        flush_q <= 1'b1;
                        if (is_excp) begin
                            excp_we_q <= 1'b1;
                            ecode_q   <= dec_ecode;
                            esub_q    <= dec_esub;
                            era_q     <= commit_pc;
                            va_err_q  <= dec_va_err;
                            bad_va_q  <= dec_bad_va;
                            tlb_q     <= dec_tlb;
                            refill_q  <= dec_refill;
                            target_q  <= dec_refill ? csr_tlbrentry : csr_eentry;
                        end else begin
                            ertn_we_q <= 1'b1;
                            target_q  <= csr_era_i;
                        end
                    end
                end
                S_CSR: begin
                    cnt_q <= 4'(FLUSH_CYCLES - 1);
                    if (FLUSH_CYCLES > 1) begin
                        state_q <= S_FLUSH;
                    end else begin
                        state_q <= S_REDIRECT;
                        flush_q <= 1'b0;
                        rv_q    <= 1'b1;
                        rpc_q   <= target_q;
                    end
                end
                S_FLUSH: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_REDIRECT;
                        flush_q <= 1'b0;
                        rv_q    <= 1'b1;
                        rpc_q   <= target_q;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        rv_q    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign flush_o        = flush_q;
    assign csr_excp_we    = excp_we_q;
    assign csr_ertn_we    = ertn_we_q;
    assign csr_ecode      = ecode_q;
    assign csr_esubcode   = esub_q;
    assign csr_era_o      = era_q;
    assign va_error       = va_err_q;
    assign bad_va         = bad_va_q;
    assign excp_tlb       = tlb_q;
    assign excp_tlbrefill = refill_q;
    assign excp_tlb_vppn  = bad_va_q[31:13];
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Scoreboard bench for excp_commit_ctrl: a cycle-age reference model queues the
// expected outputs per cycle, an independent monitor pops and compares them.
module tb_excp_commit_ctrl;

    localparam int          FC     = 2;
    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [5:0]  ECODE [16] = '{6'h00, 6'h08, 6'h3F, 6'h03, 6'h07, 6'h0B, 6'h0C, 6'h0D,
                                           6'h0E, 6'h09, 6'h08, 6'h3F, 6'h04, 6'h07, 6'h02, 6'h01};

    logic        clk, rst;
    logic        commit_valid, commit_is_ertn, redirect_ready;
    logic [31:0] commit_pc, commit_vaddr, csr_eentry, csr_tlbrentry, csr_era_i;
    logic [15:0] commit_excp_num;
    logic        busy, flush_o, csr_excp_we, csr_ertn_we, va_error, excp_tlb, excp_tlbrefill, redirect_valid;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_era_o, bad_va, redirect_pc;
    logic [18:0] excp_tlb_vppn;

    excp_commit_ctrl #(.FLUSH_CYCLES(FC), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_excp_num(commit_excp_num),
        .commit_vaddr(commit_vaddr), .commit_is_ertn(commit_is_ertn),
        .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era_i(csr_era_i),
        .redirect_ready(redirect_ready),
        .busy(busy), .flush_o(flush_o), .csr_excp_we(csr_excp_we), .csr_ertn_we(csr_ertn_we),
        .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode), .csr_era_o(csr_era_o),
        .va_error(va_error), .bad_va(bad_va), .excp_tlb(excp_tlb), .excp_tlbrefill(excp_tlbrefill),
        .excp_tlb_vppn(excp_tlb_vppn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        int          cyc;
        logic        busy, flush, rv, exwe, erwe, vaerr, tlb, refill, chk_rpc;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] era, badva, rpc;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          m_act = 0;
    int          m_age = 0;
    logic [31:0] m_tgt = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", n, cyc, act, exp);
        end
    endtask

    // Reference: outputs follow from the age of the sequence (cycles since trigger).
    task automatic model_step();
        exp_t e;
        int   b;
        e = '0;
        e.cyc = cyc + 1;
        if (rst) begin
            m_act     = 0;
            e.chk_rpc = 1'b1;
            e.rpc     = RST_PC;
        end else if (!m_act) begin
            if (commit_valid && (commit_excp_num != 16'h0 || commit_is_ertn)) begin
                m_act   = 1;
                m_age   = 1;
                e.busy  = 1'b1;
                e.flush = 1'b1;
                if (commit_excp_num != 16'h0) begin
                    b = 0;
                    for (int i = 15; i >= 0; i--) if (commit_excp_num[i]) b = i;
                    e.exwe   = 1'b1;
                    e.ecode  = ECODE[b];
                    e.esub   = (b == 10) ? 9'd1 : 9'd0;
                    e.era    = commit_pc;
                    if (b >= 1 && b <= 4) begin e.vaerr = 1'b1; e.badva = commit_pc; end
                    if (b >= 9)           begin e.vaerr = 1'b1; e.badva = commit_vaddr; end
                    e.tlb    = (b >= 2 && b <= 4) || b >= 11;
                    e.refill = (b == 2) || (b == 11);
                    m_tgt    = e.refill ? csr_tlbrentry : csr_eentry;
                end else begin
                    e.erwe = 1'b1;
                    m_tgt  = csr_era_i;
                end
            end
        end else begin
            if (m_age >= FC + 1 && redirect_ready) begin
                m_act = 0;
            end else begin
                m_age++;
                e.busy  = 1'b1;
                e.flush = (m_age <= FC);
                e.rv    = (m_age >= FC + 1);
                e.rpc   = m_tgt;
            end
        end
        sb.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [31:0] va, input logic [15:0] ex, input logic ertn);
        commit_valid    = 1'b1;
        commit_pc       = pc;
        commit_vaddr    = va;
        commit_excp_num = ex;
        commit_is_ertn  = ertn;
        step();
        commit_valid    = 1'b0;
        commit_excp_num = '0;
        commit_is_ertn  = 1'b0;
    endtask

    task automatic drain();
        redirect_ready = 1'b1;
        for (int i = 0; i < 50 && m_act; i++) step();
        step();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            me = sb.pop_front();
            chk("busy",     32'(busy),           32'(me.busy));
            chk("flush",    32'(flush_o),        32'(me.flush));
            chk("rvalid",   32'(redirect_valid), 32'(me.rv));
            chk("excp_we",  32'(csr_excp_we),    32'(me.exwe));
            chk("ertn_we",  32'(csr_ertn_we),    32'(me.erwe));
            chk("ecode",    32'(csr_ecode),      32'(me.ecode));
            chk("esub",     32'(csr_esubcode),   32'(me.esub));
            chk("era",      csr_era_o,           me.era);
            chk("va_error", 32'(va_error),       32'(me.vaerr));
            chk("bad_va",   bad_va,              me.badva);
            chk("tlb",      32'(excp_tlb),       32'(me.tlb));
            chk("refill",   32'(excp_tlbrefill), 32'(me.refill));
            chk("vppn",     32'(excp_tlb_vppn),  32'(me.badva[31:13]));
            if (me.rv || me.chk_rpc) chk("rpc", redirect_pc, me.rpc);
        end
    end

    initial begin
        rst = 1'b1; commit_valid = 1'b0; commit_is_ertn = 1'b0; redirect_ready = 1'b1;
        commit_pc = '0; commit_vaddr = '0; commit_excp_num = '0;
        csr_eentry = 32'h1c008000; csr_tlbrentry = 32'h1c00f000; csr_era_i = 32'h1c000480;
        repeat (3) step();
        rst = 1'b0;
        step();

        commit(32'h1c000100, 32'h1c000203, 16'h0200, 1'b0);   // ALE
        drain();
        commit(32'h1c000104, 32'h1c000300, 16'h0021, 1'b0);   // INT beats SYS
        drain();
        commit(32'h40002004, 32'h0, 16'h0004, 1'b0);          // fetch TLBR
        drain();
        commit(32'h1c000200, 32'h0, 16'h0000, 1'b1);          // ERTN
        drain();
        commit(32'h1c000200, 32'h0, 16'h0040, 1'b1);          // BRK wins over ERTN
        drain();

        // commit_valid low must never trigger
        commit_excp_num = 16'hffff; commit_is_ertn = 1'b1;
        step(); step();
        commit_excp_num = '0; commit_is_ertn = 1'b0;

        // backpressure, with a commit arriving mid-wait
        redirect_ready = 1'b0;
        commit(32'h1c000110, 32'h1c000207, 16'h0200, 1'b0);
        repeat (FC) step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin commit_valid = 1'b1; commit_excp_num = 16'h0020; end
            step();
            commit_valid = 1'b0; commit_excp_num = '0;
        end
        drain();

        // reset during flush
        commit(32'h1c000120, 32'h1c000400, 16'h0400, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();

        for (int n = 0; n < 2500; n++) begin
            rst            = ($urandom_range(0, 299) == 0);
            commit_valid   = ($urandom_range(0, 2) == 0);
            commit_is_ertn = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       commit_excp_num = '0;
                1:       commit_excp_num = 16'h1 << $urandom_range(0, 15);
                2:       commit_excp_num = 16'($urandom);
                default: commit_excp_num = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            commit_pc      = $urandom;
            commit_vaddr   = $urandom;
            csr_eentry     = $urandom;
            csr_tlbrentry  = $urandom;
            csr_era_i      = $urandom;
            redirect_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 1'b0; commit_valid = 1'b0;
        drain();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
